// File: rtl/seq_mult_pkg.sv
// Shared types for the sequential shift-add multiplier.
// Signed operation is enabled by SEQ_SHIFT_ADD_MULT_SIGNED_EN.
package seq_mult_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIXUP,
    DONE
  } state_e;

  function automatic int cnt_w(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/seq_shift_add_multiplier_if.sv
// Operand/product valid-ready bundle for the shift-add multiplier.
// Width follows the WIDTH parameter; product is 2*WIDTH bits.
interface seq_shift_add_multiplier_if #(
  parameter int WIDTH = 4
);

  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] p;
  logic               busy;

  modport master (
    output in_valid,
    output a,
    output b,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  p,
    input  busy
  );

  modport slave (
    input  in_valid,
    input  a,
    input  b,
    input  out_ready,
    output in_ready,
    output out_valid,
    output p,
    output busy
  );

endinterface

// File: rtl/seq_mult_datapath.sv
// Multiplicand/multiplier/accumulator registers and add-shift step.
// SEQ_SHIFT_ADD_MULT_SIGNED_EN: operands loaded as magnitudes plus sign.
module seq_mult_datapath #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               step,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] acc,
  output logic [2*WIDTH-1:0] acc_nxt,
  output logic               neg
);

  localparam int PW = 2 * WIDTH;

  logic [PW-1:0]    mcand_q, mcand_d;
  logic [PW-1:0]    acc_q, acc_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic             neg_q, neg_d;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic             neg_in;

`ifdef SEQ_SHIFT_ADD_MULT_SIGNED_EN
  // -2^(W-1) negates to itself, which reads correctly as unsigned
  always_comb begin
    a_mag  = a[WIDTH-1] ? -a : a;
    b_mag  = b[WIDTH-1] ? -b : b;
    neg_in = a[WIDTH-1] ^ b[WIDTH-1];
  end
`else
  always_comb begin
    a_mag  = a;
    b_mag  = b;
    neg_in = 1'b0;
  end
`endif

  assign acc_nxt = mplier_q[0] ? acc_q + mcand_q : acc_q;

  always_comb begin
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    neg_d    = neg_q;
    if (load) begin
      mcand_d  = {{WIDTH{1'b0}}, a_mag};
      mplier_d = b_mag;
      acc_d    = '0;
      neg_d    = neg_in;
    end else if (step) begin
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      acc_d    = acc_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      neg_q    <= 1'b0;
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      neg_q    <= neg_d;
    end
  end

  assign acc = acc_q;
  assign neg = neg_q;

endmodule

// File: rtl/seq_shift_add_multiplier.sv
// Sequential shift-add multiplier: FSM, iteration counter, handshakes.
// SEQ_SHIFT_ADD_MULT_SIGNED_EN adds a one-cycle sign FIXUP state.
module seq_shift_add_multiplier
  import seq_mult_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic clk,
  input  logic rst,
  seq_shift_add_multiplier_if.slave bus
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = cnt_w(WIDTH);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] p_q, p_d;
  logic          load, step;
  logic [PW-1:0] acc, acc_nxt;
  logic          neg;

  seq_mult_datapath #(
    .WIDTH(WIDTH)
  ) u_dp (
    .clk    (clk),
    .rst    (rst),
    .load   (load),
    .step   (step),
    .a      (bus.a),
    .b      (bus.b),
    .acc    (acc),
    .acc_nxt(acc_nxt),
    .neg    (neg)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    p_d     = p_q;
    load    = 1'b0;
    step    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          load    = 1'b1;
          cnt_d   = CW'(WIDTH);
          state_d = RUN;
        end
      end
      RUN: begin
        step  = 1'b1;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) begin
`ifdef SEQ_SHIFT_ADD_MULT_SIGNED_EN
          state_d = FIXUP;
`else
          p_d     = acc_nxt;
          state_d = DONE;
`endif
        end
      end
      FIXUP: begin
        p_d     = neg ? -acc : acc;
        state_d = DONE;
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      p_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.p         = p_q;

endmodule

// File: tb/tb_seq_shift_add_multiplier.sv
// Self-checking bench for seq_shift_add_multiplier (WIDTH=4).
// Honours SEQ_SHIFT_ADD_MULT_SIGNED_EN for signed expectations.
module tb_seq_shift_add_multiplier;

  localparam int W  = 4;
  localparam int PW = 2 * W;
`ifdef SEQ_SHIFT_ADD_MULT_SIGNED_EN
  localparam int LAT = W + 1;
`else
  localparam int LAT = W;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  seq_shift_add_multiplier_if #(.WIDTH(W)) bus ();

  seq_shift_add_multiplier #(.WIDTH(W)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_cmp  = 0;
  int n_fail = 0;
  logic [PW-1:0] sb[$];

  typedef struct {
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    int            hold;
    logic [PW-1:0] exp;
  } vec_t;

  vec_t vt[$];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [PW-1:0] model(input logic [W-1:0] x,
                                           input logic [W-1:0] y);
    logic [PW-1:0] ex, ey;
`ifdef SEQ_SHIFT_ADD_MULT_SIGNED_EN
    ex = {{W{x[W-1]}}, x};
    ey = {{W{y[W-1]}}, y};
`else
    ex = {{W{1'b0}}, x};
    ey = {{W{1'b0}}, y};
`endif
    return PW'(ex * ey);
  endfunction

  task automatic do_op(input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic [PW-1:0] exp, input int hold,
                       input bit noise);
    int t;
    int lat;
    logic [PW-1:0] e;
    logic [PW-1:0] p0;
    t = 0;
    while (!bus.in_ready && t < 20) begin
      @(posedge clk); #1;
      t++;
    end
    if (!bus.in_ready) begin
      chk("in_ready_wait", 0, 1);
      return;
    end
    bus.in_valid = 1'b1;
    bus.a = x;
    bus.b = y;
    sb.push_back(exp);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    chk("busy_after_accept", bus.busy, 1);
    lat = 0;
    while (!bus.out_valid && lat < 40) begin
      if (noise) begin
        bus.in_valid = 1'($urandom_range(0, 1));
        bus.a = W'($urandom);
        bus.b = W'($urandom);
      end
      @(posedge clk); #1;
      lat++;
    end
    bus.in_valid = 1'b0;
    chk("latency", lat, LAT);
    if (!bus.out_valid) return;
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 1, 0);
      return;
    end
    e = sb.pop_front();
    chk("product", bus.p, e);
    chk("in_ready_in_done", bus.in_ready, 0);
    p0 = bus.p;
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      chk("backpressure_hold", {bus.out_valid, bus.in_ready, bus.p},
          {1'b1, 1'b0, p0});
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk("out_valid_drop", bus.out_valid, 0);
    chk("in_ready_after_hs", bus.in_ready, 1);
    chk("p_retained", bus.p, p0);
  endtask

  task automatic chk_reset_state(input string nm);
    chk({nm, "_in_ready"}, bus.in_ready, 1);
    chk({nm, "_out_valid"}, bus.out_valid, 0);
    chk({nm, "_busy"}, bus.busy, 0);
    chk({nm, "_p"}, bus.p, 0);
  endtask

  initial begin
    bit seen;
    logic [W-1:0] ra, rb;
    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.a = '0;
    bus.b = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_state("reset");
    rst = 1'b0;

`ifdef SEQ_SHIFT_ADD_MULT_SIGNED_EN
    vt.push_back('{4'h8, 4'h8, 0, 8'h40});
    vt.push_back('{4'h8, 4'h7, 0, 8'hC8});
    vt.push_back('{4'hF, 4'h1, 0, 8'hFF});
    vt.push_back('{4'h0, 4'hB, 0, 8'h00});
    vt.push_back('{4'h5, 4'h0, 0, 8'h00});
    vt.push_back('{4'hB, 4'hD, 10, 8'h0F});
    vt.push_back('{4'hF, 4'hF, 2, 8'h01});
`else
    vt.push_back('{4'd15, 4'd15, 0, 8'd225});
    vt.push_back('{4'd12, 4'd14, 0, 8'd168});
    vt.push_back('{4'd5, 4'd0, 0, 8'd0});
    vt.push_back('{4'd0, 4'd13, 0, 8'd0});
    vt.push_back('{4'd11, 4'd13, 10, 8'd143});
    vt.push_back('{4'd1, 4'd15, 3, 8'd15});
`endif

    foreach (vt[i]) do_op(vt[i].a, vt[i].b, vt[i].exp, vt[i].hold, 1'b0);

    // Reset two cycles into an operation must abandon it
    bus.in_valid = 1'b1;
    bus.a = 4'd7;
    bus.b = 4'd9;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk_reset_state("mid_reset");
    seen = 1'b0;
    for (int c = 0; c < W + 3; c++) begin
      @(posedge clk); #1;
      if (bus.out_valid) seen = 1'b1;
    end
    chk("no_out_valid_after_reset", seen, 0);
    do_op(4'd3, 4'd3, model(4'd3, 4'd3), 0, 1'b0);

    for (int i = 0; i < 16; i++)
      for (int j = 0; j < 16; j++)
        do_op(W'(i), W'(j), model(W'(i), W'(j)), 0, 1'b0);

    for (int k = 0; k < 20; k++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      do_op(ra, rb, model(ra, rb), 0, 1'b1);
    end

    chk("scoreboard_drained", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
